// File: rtl/serial_subtractor_ctrl.sv
// ---------------------------------------------------------------------------
// serial_subtractor_ctrl
//
// Bit-serial subtractor with a small control FSM. It computes
// diff = a - b - bin (modulo 2^WIDTH) one bit per clock, LSB first, using a
// single full-subtractor stage. A request is accepted only while idle. The
// result registers change only when an operation finishes, so diff, bout and
// ovf always show the last completed result.
//
// Parameters
//   WIDTH  operand/result width in bits (2..32)
//
// Ports
//   clk    in   single clock, rising edge
//   rst    in   synchronous active-high reset
//   start  in   begin a subtraction (sampled only when idle)
//   a      in   minuend, captured on the accepting edge
//   b      in   subtrahend, captured on the accepting edge
//   bin    in   initial borrow-in, captured on the accepting edge
//   busy   out  high while bits are being processed
//   done   out  one-cycle pulse when diff/bout/ovf hold a fresh result
//   diff   out  a - b - bin modulo 2^WIDTH
//   bout   out  borrow out of the MSB stage (a < b + bin, unsigned)
//   ovf    out  two's-complement overflow flag
// ---------------------------------------------------------------------------
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter only has to index bits 0..WIDTH-1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  // Single full-subtractor stage working on the current LSBs of the operand
  // shift registers.
  logic x_bit;
  logic y_bit;
  logic d_bit;
  logic br_next;
  logic [WIDTH-1:0] acc_next;

  always_comb begin
    x_bit    = a_sh_q[0];
    y_bit    = b_sh_q[0];
    d_bit    = x_bit ^ y_bit ^ br_q;
    br_next  = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & br_q);
    // Difference bits enter at the MSB, so after WIDTH shifts the first
    // (LSB) result bit has travelled down to bit 0.
    acc_next = {d_bit, acc_q[WIDTH-1:1]};
  end

  // Next-state and datapath control. The accumulator is kept separate from
  // diff_q so partial results never appear on the output.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = bin;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        br_d   = br_next;
        acc_d  = acc_next;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // On the MSB stage x_bit/y_bit are the captured operand MSBs and
          // d_bit is the result MSB, which is all the overflow rule needs.
          diff_d  = acc_next;
          bout_d  = br_next;
          ovf_d   = (x_bit != y_bit) && (d_bit != x_bit);
          cnt_d   = '0;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Synchronous reset clears the whole datapath, which also discards any
  // operation that was in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule
